// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory bus and decode handshake bundle for ifetch_unit
interface ifetch_unit_if #(
  parameter int ISIZE = 32,
  parameter int DSIZE = 32
);
  // instruction memory side
  logic [ISIZE-1:0] imem_addr;
  logic             imem_wen;
  logic [DSIZE-1:0] imem_wdata;
  logic [DSIZE-1:0] imem_rdata;
  // decode side
  logic             instr_valid;
  logic             instr_ready;
  logic [DSIZE-1:0] instr;
  logic [ISIZE-1:0] instr_pc;
  logic             fifo_full;

  // fetch unit view
  modport master (
    output imem_addr, imem_wen, imem_wdata,
    input  imem_rdata,
    output instr_valid, instr, instr_pc, fifo_full,
    input  instr_ready
  );

  // memory + decode view
  modport slave (
    input  imem_addr, imem_wen, imem_wdata,
    output imem_rdata,
    input  instr_valid, instr, instr_pc, fifo_full,
    output instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC-driven instruction fetch with prefetch FIFO and branch redirect
module ifetch_unit #(
  parameter int               ISIZE      = 32,
  parameter int               DSIZE      = 32,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [ISIZE-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [ISIZE-1:0] redirect_pc,
  ifetch_unit_if.master    bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ISIZE-1:0] pc;
  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [ISIZE-1:0] pc_q   [FIFO_DEPTH];
  logic [DSIZE-1:0] word_q [FIFO_DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic push;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & bus.instr_ready;
  // a pop frees a slot in the same cycle, so a full queue still accepts a word
  assign push  = fetch_en & ~redirect_valid & (~full | pop);

  // memory is read-only from this unit; the address is the PC register itself
  assign bus.imem_addr  = pc;
  assign bus.imem_wen   = 1'b0;
  assign bus.imem_wdata = '0;

  // head of queue comes straight from registered storage, never from instr_ready
  assign bus.instr_valid = ~empty;
  assign bus.instr       = word_q[rd_ptr];
  assign bus.instr_pc    = pc_q[rd_ptr];
  assign bus.fifo_full   = full;

  // PC, occupancy and pointers; a redirect flushes by snapping rd_ptr to wr_ptr
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        pc     <= pc + ISIZE'(1);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // capture the word returned for the current PC together with its address
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wr_ptr]   <= pc;
      word_q[wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests_run = 0;
  int tests_failed = 0;

  ifetch_unit_if #(.ISIZE(32), .DSIZE(32)) bus ();
  ifetch_unit_if #(.ISIZE(4),  .DSIZE(32)) bus4 ();

  ifetch_unit #(.ISIZE(32), .DSIZE(32), .FIFO_DEPTH(4), .RESET_PC(32'd0)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus)
  );

  ifetch_unit #(.ISIZE(4), .DSIZE(32), .FIFO_DEPTH(4), .RESET_PC(4'd14)) u_dut4 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc[3:0]), .bus(bus4)
  );

  // clock generator
  always #5 clk = ~clk;

  // instruction memory contents
  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'd0:   word_of = 32'h0000_0000;
      32'd1:   word_of = 32'h0503_1000;
      32'd2:   word_of = 32'h0043_0800;
      32'd3:   word_of = 32'h0901_F000;
      32'd6:   word_of = 32'h18E4_0001;
      default: word_of = 32'hC0DE_0000 | a;
    endcase
  endfunction

  // combinational read memories
  assign bus.imem_rdata  = word_of(bus.imem_addr);
  assign bus4.imem_rdata = word_of({28'd0, bus4.imem_addr});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    bus.instr_ready  = r;
    bus4.instr_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    set_ready(1'b0);

    // reset state
    tick();
    check("rst_addr",  bus.imem_addr, 32'd0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_full",  bus.fifo_full, 1'b0);
    check("rst_wen",   bus.imem_wen, 1'b0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_addr4", bus4.imem_addr, 32'd14);
    rst = 1'b0;

    // 1: sequential fetch, one word per cycle
    fetch_en = 1'b1;
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_valid", bus.instr_valid, 1'b1);
      check("seq_pc",    bus.instr_pc, 32'(i));
      check("seq_word",  bus.instr, word_of(32'(i)));
      check("seq_wen",   bus.imem_wen, 1'b0);
    end

    // 2: backpressure fills the queue, then drain with fetch frozen
    do_reset();
    set_ready(1'b0);
    fetch_en = 1'b1;
    tick(); tick(); tick();
    check("bp_notfull3", bus.fifo_full, 1'b0);
    tick();
    check("bp_full4", bus.fifo_full, 1'b1);
    check("bp_pc4",   bus.imem_addr, 32'd4);
    tick(); tick();
    check("bp_full6", bus.fifo_full, 1'b1);
    check("bp_pc6",   bus.imem_addr, 32'd4);
    fetch_en = 1'b0;
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", bus.instr_valid, 1'b1);
      check("bp_drain_pc",    bus.instr_pc, 32'(i));
      check("bp_drain_word",  bus.instr, word_of(32'(i)));
      tick();
    end
    check("bp_empty",  bus.instr_valid, 1'b0);
    check("bp_frozen", bus.imem_addr, 32'd4);

    // 3: redirect flushes queued pc 2..4
    do_reset();
    fetch_en = 1'b1;
    set_ready(1'b1);
    tick(); tick(); tick();
    set_ready(1'b0);
    tick(); tick();
    check("rd_head2", bus.instr_pc, 32'd2);
    check("rd_pc5",   bus.imem_addr, 32'd5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd6;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush_valid", bus.instr_valid, 1'b0);
    check("rd_addr6",       bus.imem_addr, 32'd6);
    tick();
    check("rd_new_valid", bus.instr_valid, 1'b1);
    check("rd_new_pc",    bus.instr_pc, 32'd6);
    check("rd_new_word",  bus.instr, 32'h18E4_0001);
    set_ready(1'b1);
    tick();
    check("rd_next_pc", bus.instr_pc, 32'd7);

    // 4: pop+push at full, then redirect with a pop
    do_reset();
    fetch_en = 1'b1;
    set_ready(1'b0);
    tick(); tick(); tick(); tick();
    check("pp_full", bus.fifo_full, 1'b1);
    set_ready(1'b1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("pp_full_hold", bus.fifo_full, 1'b1);
      check("pp_pc",        bus.instr_pc, 32'(j));
    end
    check("pp_addr12", bus.imem_addr, 32'd12);
    check("rp_head8",  bus.instr_pc, 32'd8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd20;
    tick();
    redirect_valid = 1'b0;
    check("rp_valid0", bus.instr_valid, 1'b0);
    check("rp_addr20", bus.imem_addr, 32'd20);
    tick();
    check("rp_pc20",  bus.instr_pc, 32'd20);
    check("rp_word",  bus.instr, word_of(32'd20));

    // 5: PC wrap on the 4-bit instance
    do_reset();
    fetch_en = 1'b1;
    set_ready(1'b1);
    tick();
    check("wrap_14", bus4.instr_pc, 32'd14);
    tick();
    check("wrap_15", bus4.instr_pc, 32'd15);
    tick();
    check("wrap_0",  bus4.instr_pc, 32'd0);
    check("wrap_w0", bus4.instr, word_of(32'd0));
    tick();
    check("wrap_1",  bus4.instr_pc, 32'd1);

    // 6: reset mid-stream with three entries queued
    do_reset();
    fetch_en = 1'b1;
    set_ready(1'b0);
    tick(); tick(); tick();
    check("mr_pc3", bus.imem_addr, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", bus.instr_valid, 1'b0);
    check("mr_addr",  bus.imem_addr, 32'd0);
    check("mr_full",  bus.fifo_full, 1'b0);
    set_ready(1'b1);
    tick();
    check("mr_refetch_pc",   bus.instr_pc, 32'd0);
    check("mr_refetch_word", bus.instr, word_of(32'd0));
    check("mr_wen",          bus.imem_wen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
